// File: rtl/parameter_pkg.sv
// Shared writeback packet type and default sizing for the writeback stage.
package parameter_pkg;

  localparam int ROB_WIDTH     = 5;
  localparam int PHY_WIDTH     = 6;
  localparam int DATA_WIDTH    = 32;
  localparam int WB_NUM_SRC    = 3;
  localparam int WB_NUM_PORTS  = 2;
  localparam int WB_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ROB_WIDTH-1:0]  rob_id;
    logic [PHY_WIDTH-1:0]  rd_phy;
    logic                  rd_we;
    logic [DATA_WIDTH-1:0] data;
  } wb_pkt_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source completion FIFO; head is read combinationally so the arbiter
// can grant and load the output registers in the same cycle.
module wb_fifo
  import parameter_pkg::*;
#(
  parameter int  DEPTH = WB_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  wb_pkt_t          push_pkt,
  input  logic             pop,
  output wb_pkt_t          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  wb_pkt_t          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage is not reset; a write discarded by clear is never reachable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Buffered writeback stage: per-source FIFOs drained round-robin onto
// NUM_WB registered writeback ports, with flush and stall accounting.
module writeback_arbiter #(
  parameter int  NUM_SRC    = parameter_pkg::WB_NUM_SRC,
  parameter int  NUM_WB     = parameter_pkg::WB_NUM_PORTS,
  parameter int  FIFO_DEPTH = parameter_pkg::WB_FIFO_DEPTH,
  parameter int  DATA_WIDTH = parameter_pkg::DATA_WIDTH,
  parameter int  PHY_WIDTH  = parameter_pkg::PHY_WIDTH,
  parameter int  ROB_WIDTH  = parameter_pkg::ROB_WIDTH,
  localparam int SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*ROB_WIDTH-1:0] src_rob_id,
  input  logic [NUM_SRC*PHY_WIDTH-1:0] src_rd_phy,
  input  logic [NUM_SRC-1:0]           src_rd_we,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_WB-1:0]            wb_valid,
  output logic [NUM_WB*ROB_WIDTH-1:0]  wb_rob_id,
  output logic [NUM_WB*PHY_WIDTH-1:0]  wb_rd_phy,
  output logic [NUM_WB-1:0]            wb_rd_we,
  output logic [NUM_WB*DATA_WIDTH-1:0] wb_data,
  output logic [NUM_WB*SRC_W-1:0]      wb_src,
  output logic [31:0]                  stall_cnt
);
  import parameter_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_pkt_t            push_pkt [NUM_SRC];
  wb_pkt_t            head [NUM_SRC];
  logic [CNT_W-1:0]   fifo_count [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;

  logic [SRC_W-1:0]   rr_ptr_reg;
  logic [SRC_W-1:0]   rr_ptr_next;
  logic [SRC_W-1:0]   slot_src [NUM_WB];
  logic [NUM_WB-1:0]  slot_vld;
  logic               stall;

  wb_pkt_t            out_pkt_reg [NUM_WB];
  logic [SRC_W-1:0]   out_src_reg [NUM_WB];
  logic [NUM_WB-1:0]  out_vld_reg;
  logic [31:0]        stall_cnt_reg;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign push_pkt[gi] = '{
      rob_id: src_rob_id[gi*ROB_WIDTH +: ROB_WIDTH],
      rd_phy: src_rd_phy[gi*PHY_WIDTH +: PHY_WIDTH],
      rd_we:  src_rd_we[gi],
      data:   src_data[gi*DATA_WIDTH +: DATA_WIDTH]
    };
    // Ready comes from registered count only, so no valid-to-ready path.
    assign src_ready[gi] = (fifo_count[gi] != CNT_W'(FIFO_DEPTH));
    assign push[gi]      = src_valid[gi] && !fifo_full[gi] && !flush;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .push     (push[gi]),
      .push_pkt (push_pkt[gi]),
      .pop      (grant[gi]),
      .head     (head[gi]),
      .count    (fifo_count[gi]),
      .full     (fifo_full[gi]),
      .empty    (fifo_empty[gi])
    );
  end

  always_comb begin
    int idx;
    int n;
    grant       = '0;
    slot_vld    = '0;
    rr_ptr_next = rr_ptr_reg;
    n           = 0;
    for (int k = 0; k < NUM_WB; k++) slot_src[k] = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = int'(rr_ptr_reg) + j;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!fifo_empty[idx] && n < NUM_WB) begin
        grant[idx]  = 1'b1;
        slot_src[n] = SRC_W'(idx);
        slot_vld[n] = 1'b1;
        n           = n + 1;
        rr_ptr_next = (idx == NUM_SRC - 1) ? '0 : SRC_W'(idx + 1);
      end
    end
    stall = |(~fifo_empty & ~grant);
  end

  // Data fields of idle slots hold; only valid is cleared by flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_vld_reg   <= '0;
      rr_ptr_reg    <= '0;
      stall_cnt_reg <= '0;
      for (int k = 0; k < NUM_WB; k++) begin
        out_pkt_reg[k] <= '0;
        out_src_reg[k] <= '0;
      end
    end else if (flush) begin
      out_vld_reg <= '0;
    end else begin
      out_vld_reg <= slot_vld;
      rr_ptr_reg  <= rr_ptr_next;
      if (stall && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      for (int k = 0; k < NUM_WB; k++) begin
        if (slot_vld[k]) begin
          out_pkt_reg[k] <= head[slot_src[k]];
          out_src_reg[k] <= slot_src[k];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_wb
    assign wb_valid[gi]                           = out_vld_reg[gi] && !flush;
    assign wb_rob_id[gi*ROB_WIDTH +: ROB_WIDTH]   = out_pkt_reg[gi].rob_id;
    assign wb_rd_phy[gi*PHY_WIDTH +: PHY_WIDTH]   = out_pkt_reg[gi].rd_phy;
    assign wb_rd_we[gi]                           = out_pkt_reg[gi].rd_we;
    assign wb_data[gi*DATA_WIDTH +: DATA_WIDTH]   = out_pkt_reg[gi].data;
    assign wb_src[gi*SRC_W +: SRC_W]              = out_src_reg[gi];
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboarded bench for writeback_arbiter: a 3-source/2-port instance for
// latency, contention, flush and reset, plus a 1-port instance for FIFO full.
module tb_writeback_arbiter;

  typedef struct {
    int          slot;
    int          src;
    logic [4:0]  rob;
    logic [5:0]  phy;
    logic        we;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk, rst, flush;
  int   cyc;
  int   n_checks, n_fail;
  exp_t sb[$];
  exp_t mon_e;

  // 3-source / 2-port instance
  logic [2:0]  s_valid, s_ready, s_we;
  logic [14:0] s_rob;
  logic [17:0] s_phy;
  logic [95:0] s_data;
  logic [1:0]  w_valid, w_we;
  logic [9:0]  w_rob;
  logic [11:0] w_phy;
  logic [63:0] w_data;
  logic [3:0]  w_src;
  logic [31:0] w_stall;

  // 3-source / 1-port instance
  logic [2:0]  d1_s_valid, d1_s_ready, d1_s_we;
  logic [14:0] d1_s_rob;
  logic [17:0] d1_s_phy;
  logic [95:0] d1_s_data;
  logic [0:0]  d1_w_valid, d1_w_we;
  logic [4:0]  d1_w_rob;
  logic [5:0]  d1_w_phy;
  logic [31:0] d1_w_data;
  logic [1:0]  d1_w_src;
  logic [31:0] d1_w_stall;
  logic        d1_flush;

  logic [2:0] exp_rdy [10] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                                3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

  writeback_arbiter u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(s_valid), .src_ready(s_ready), .src_rob_id(s_rob),
    .src_rd_phy(s_phy), .src_rd_we(s_we), .src_data(s_data),
    .wb_valid(w_valid), .wb_rob_id(w_rob), .wb_rd_phy(w_phy),
    .wb_rd_we(w_we), .wb_data(w_data), .wb_src(w_src), .stall_cnt(w_stall)
  );

  writeback_arbiter #(.NUM_SRC(3), .NUM_WB(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(d1_flush),
    .src_valid(d1_s_valid), .src_ready(d1_s_ready), .src_rob_id(d1_s_rob),
    .src_rd_phy(d1_s_phy), .src_rd_we(d1_s_we), .src_data(d1_s_data),
    .wb_valid(d1_w_valid), .wb_rob_id(d1_w_rob), .wb_rd_phy(d1_w_phy),
    .wb_rd_we(d1_w_we), .wb_data(d1_w_data), .wb_src(d1_w_src),
    .stall_cnt(d1_w_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] f_rob(input int s, input int q);
    return 5'(s * 8 + q);
  endfunction
  function automatic logic [5:0] f_phy(input int s, input int q);
    return 6'(s * 16 + q + 1);
  endfunction
  function automatic logic f_we(input int s, input int q);
    return ((s + q) % 3) != 2;
  endfunction
  function automatic logic [31:0] f_data(input int s, input int q);
    return 32'hC0DE_0000 | 32'(s << 8) | 32'(q);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input int q, input bit v);
    s_valid[s]         = v;
    s_rob[s*5 +: 5]    = f_rob(s, q);
    s_phy[s*6 +: 6]    = f_phy(s, q);
    s_we[s]            = f_we(s, q);
    s_data[s*32 +: 32] = f_data(s, q);
  endtask

  task automatic d1_drive(input int s, input int q);
    d1_s_valid[s]         = 1'b1;
    d1_s_rob[s*5 +: 5]    = f_rob(s, q);
    d1_s_phy[s*6 +: 6]    = f_phy(s, q);
    d1_s_we[s]            = f_we(s, q);
    d1_s_data[s*32 +: 32] = f_data(s, q);
  endtask

  task automatic expect_pkt(input int slot, input int s, input int q, input int c);
    exp_t e;
    e.slot = slot; e.src = s; e.rob = f_rob(s, q); e.phy = f_phy(s, q);
    e.we = f_we(s, q); e.data = f_data(s, q); e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    s_valid = '0; d1_s_valid = '0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Monitor: every valid writeback slot must match the next queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (w_valid[k] === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected slot %0d @cyc %0d: got rob %0h src %0h, required no packet",
                   k, cyc, w_rob[k*5 +: 5], w_src[k*2 +: 2]);
        end else begin
          mon_e = sb.pop_front();
          chk("wb_slot", 64'(k), 64'(mon_e.slot));
          chk("wb_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("wb_src", 64'(w_src[k*2 +: 2]), 64'(mon_e.src));
          chk("wb_rob_id", 64'(w_rob[k*5 +: 5]), 64'(mon_e.rob));
          chk("wb_rd_phy", 64'(w_phy[k*6 +: 6]), 64'(mon_e.phy));
          chk("wb_rd_we", 64'(w_we[k]), 64'(mon_e.we));
          chk("wb_data", 64'(w_data[k*32 +: 32]), 64'(mon_e.data));
        end
      end
    end
  end

  initial begin
    int b;
    int d1_seq [3];
    logic [2:0] r;
    exp_t e;
    n_checks = 0; n_fail = 0;
    flush = 1'b0; d1_flush = 1'b0; rst = 1'b0;
    s_valid = '0; s_rob = '0; s_phy = '0; s_we = '0; s_data = '0;
    d1_s_valid = '0; d1_s_rob = '0; d1_s_phy = '0; d1_s_we = '0; d1_s_data = '0;

    // Reset state
    do_reset();
    chk("rst_wb_valid", 64'(w_valid), 64'd0);
    chk("rst_wb_rob_id", 64'(w_rob), 64'd0);
    chk("rst_wb_data", w_data, 64'd0);
    chk("rst_wb_src", 64'(w_src), 64'd0);
    chk("rst_src_ready", 64'(s_ready), 64'b111);
    chk("rst_stall_cnt", 64'(w_stall), 64'd0);

    // FIFO full on the single-port instance: all sources push while ready
    for (int s = 0; s < 3; s++) d1_seq[s] = 0;
    for (int c = 0; c < 10; c++) begin
      chk("full_src_ready", 64'(d1_s_ready), 64'(exp_rdy[c]));
      if (c >= 2) begin
        chk("full_wb_valid", 64'(d1_w_valid), 64'd1);
        chk("full_wb_src", 64'(d1_w_src), 64'((c - 2) % 3));
        chk("full_wb_rob_id", 64'(d1_w_rob), 64'(f_rob((c - 2) % 3, (c - 2) / 3)));
      end else begin
        chk("full_wb_valid", 64'(d1_w_valid), 64'd0);
      end
      if (c == 9) chk("full_stall_cnt", 64'(d1_w_stall), 64'd8);
      for (int s = 0; s < 3; s++) d1_drive(s, d1_seq[s]);
      r = d1_s_ready;
      tick();
      for (int s = 0; s < 3; s++) if (r[s]) d1_seq[s]++;
    end
    d1_s_valid = '0;

    // Single packet latency
    do_reset();
    b = cyc;
    s_valid = 3'b001; s_rob[4:0] = 5'd3; s_phy[5:0] = 6'd12; s_we[0] = 1'b1;
    s_data[31:0] = 32'hDEAD_BEEF;
    e.slot = 0; e.src = 0; e.rob = 5'd3; e.phy = 6'd12; e.we = 1'b1;
    e.data = 32'hDEAD_BEEF; e.cyc = b + 2;
    sb.push_back(e);
    tick();
    s_valid = '0;
    chk("single_early_valid", 64'(w_valid), 64'd0);
    tick();
    chk("single_wb_valid", 64'(w_valid), 64'b01);
    tick(); tick();

    // Contention: grants rotate 0,1,2,0,... across the two slots
    do_reset();
    b = cyc;
    for (int k = 0; k < 18; k++) expect_pkt(k % 2, k % 3, k / 3, b + 2 + k / 2);
    for (int c = 0; c < 6; c++) begin
      chk("cont_src_ready", 64'(s_ready), 64'b111);
      if (c == 2) chk("cont_stall_first", 64'(w_stall), 64'd1);
      for (int s = 0; s < 3; s++) drive(s, c, 1'b1);
      tick();
    end
    s_valid = '0;
    for (int i = 0; i < 5; i++) tick();
    chk("cont_stall_cnt", 64'(w_stall), 64'd8);
    chk("cont_sb_drained", 64'(sb.size()), 64'd0);

    // Flush with packets buffered and writeback valid
    b = cyc;
    for (int k = 0; k < 6; k++) expect_pkt(k % 2, k % 3, k / 3, b + 2 + k / 2);
    for (int c = 0; c < 5; c++) begin
      for (int s = 0; s < 3; s++) drive(s, c, 1'b1);
      tick();
    end
    chk("flush_pre_valid", 64'(w_valid), 64'b11);
    flush = 1'b1;
    s_valid = 3'b010; s_rob[9:5] = 5'd31; s_data[63:32] = 32'hBAD0_BAD0;
    #2;
    chk("flush_gated_valid", 64'(w_valid), 64'd0);
    tick();
    flush = 1'b0; s_valid = '0;
    chk("flush_next_valid", 64'(w_valid), 64'd0);
    chk("flush_src_ready", 64'(s_ready), 64'b111);
    chk("flush_stall_cnt", 64'(w_stall), 64'd12);
    // rr pointer survived the flush at 2, so source 2 lands on slot 0
    drive(0, 6, 1'b1);
    drive(2, 6, 1'b1);
    expect_pkt(0, 2, 6, cyc + 2);
    expect_pkt(1, 0, 6, cyc + 2);
    tick();
    s_valid = '0;
    tick(); tick(); tick();
    chk("flush_stall_hold", 64'(w_stall), 64'd12);
    chk("flush_sb_drained", 64'(sb.size()), 64'd0);

    // Mid-traffic reset
    b = cyc;
    expect_pkt(0, 1, 0, b + 2);
    expect_pkt(1, 2, 0, b + 2);
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 3; s++) drive(s, c, 1'b1);
      tick();
    end
    for (int s = 0; s < 3; s++) drive(s, 2, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1; s_valid = '0;
    chk("mrst_wb_valid", 64'(w_valid), 64'd0);
    chk("mrst_wb_rob_id", 64'(w_rob), 64'd0);
    chk("mrst_wb_rd_phy", 64'(w_phy), 64'd0);
    chk("mrst_wb_rd_we", 64'(w_we), 64'd0);
    chk("mrst_wb_data", w_data, 64'd0);
    chk("mrst_wb_src", 64'(w_src), 64'd0);
    chk("mrst_stall_cnt", 64'(w_stall), 64'd0);
    chk("mrst_src_ready", 64'(s_ready), 64'b111);
    drive(2, 7, 1'b1);
    expect_pkt(0, 2, 7, cyc + 2);
    tick();
    s_valid = '0;
    tick();
    chk("mrst_first_valid", 64'(w_valid), 64'b01);
    tick(); tick();
    chk("final_sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
